// File: rtl/sobel_window_buffer.sv
// 3x3 sliding-window generator for the Sobel core: two line buffers plus a
// column-shifting window register, fed by a raster-order pixel stream.
module sobel_window_buffer #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int IMG_WIDTH      = 16,
    parameter int IMG_HEIGHT     = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        px_valid_i,
    input  logic [MAX_PIXEL_BITS-1:0]   px_gray_i,
    input  logic                        sof_i,
    output logic [9*MAX_PIXEL_BITS-1:0] window_o,
    output logic                        window_valid_o,
    output logic                        frame_done_o,
    output logic                        busy_o
);

    localparam int P     = MAX_PIXEL_BITS;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ACTIVE} state_t;

    state_t           state;
    state_t           state_eff;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_eff;
    logic             at_row_end;
    logic             at_frame_end;

    logic [P-1:0]     line1 [IMG_WIDTH];
    logic [P-1:0]     line2 [IMG_WIDTH];
    logic [P-1:0]     col_top;
    logic [P-1:0]     col_mid;

    logic [9*P-1:0]   win_p1;
    logic             vld_p1;
    logic             done_p1;

    // A start-of-frame pixel is treated as pixel (0,0) from an idle state.
    assign col_eff      = sof_i ? '0 : col;
    assign row_eff      = sof_i ? '0 : row;
    assign state_eff    = sof_i ? S_IDLE : state;
    assign at_row_end   = (col_eff == COL_LAST);
    assign at_frame_end = at_row_end && (row_eff == ROW_LAST);

    assign col_top = line2[col_eff];
    assign col_mid = line1[col_eff];

    // ---- stage 0: accept pixel, update line buffers ----
    always_ff @(posedge clk_i) begin
        if (px_valid_i) begin
            line2[col_eff] <= line1[col_eff];
            line1[col_eff] <= px_gray_i;
        end
    end

    // ---- stage 1: window register, shifted one column per accepted pixel ----
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            win_p1 <= '0;
        end else if (px_valid_i) begin
            for (int r = 0; r < 3; r++) begin
                win_p1[(3*r)*P   +: P] <= win_p1[(3*r+1)*P +: P];
                win_p1[(3*r+1)*P +: P] <= win_p1[(3*r+2)*P +: P];
            end
            win_p1[2*P +: P] <= col_top;
            win_p1[5*P +: P] <= col_mid;
            win_p1[8*P +: P] <= px_gray_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= S_IDLE;
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (sof_i) begin
                state <= S_IDLE;
                col   <= '0;
                row   <= '0;
            end
            if (px_valid_i) begin
                // Windows never straddle a row: the two oldest columns must be in this row.
                vld_p1  <= (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
                done_p1 <= at_frame_end;
                if (at_row_end) begin
                    col <= '0;
                    row <= at_frame_end ? '0 : row_eff + ROW_ONE;
                end else begin
                    col <= col_eff + COL_ONE;
                    row <= row_eff;
                end
                case (state_eff)
                    S_IDLE:   state <= S_FILL;
                    S_FILL:   if (row_eff == ROW_ONE && at_row_end) state <= S_ACTIVE;
                    S_ACTIVE: if (at_frame_end) state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign window_o       = win_p1;
    assign window_valid_o = vld_p1;
    assign frame_done_o   = done_p1;
    assign busy_o         = (state != S_IDLE);

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image with a scoreboard of
// expected windows built from a bench-side copy of the image.
module tb_sobel_window_buffer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           px_valid_i;
    logic [P-1:0]   px_gray_i;
    logic           sof_i;
    logic [9*P-1:0] window_o;
    logic           window_valid_o;
    logic           frame_done_o;
    logic           busy_o;

    sobel_window_buffer #(
        .MAX_PIXEL_BITS(P),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .px_valid_i(px_valid_i),
        .px_gray_i(px_gray_i),
        .sof_i(sof_i),
        .window_o(window_o),
        .window_valid_o(window_valid_o),
        .frame_done_o(frame_done_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9*P-1:0] win;
        logic           done;
    } exp_t;

    exp_t           sb_q[$];
    logic [9*P-1:0] got_q[$];
    exp_t           mon_e;
    int             n_assert = 0;
    int             n_fail   = 0;
    int             win_cnt  = 0;
    int             done_cnt = 0;
    int             m_row    = 0;
    int             m_col    = 0;
    int             img [H][W];

    function automatic logic [9*P-1:0] win_at(input int base);
        logic [9*P-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*P +: P] = P'(base + W*i + j);
        return w;
    endfunction

    task automatic check(input string tag, input logic [9*P-1:0] obs, input logic [9*P-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [P-1:0] v, input logic sof);
        exp_t e;
        if (sof) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = int'(v);
        if (m_row >= 2 && m_col >= 2) begin
            e.win = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(3*i+j)*P +: P] = P'(img[m_row-2+i][m_col-2+j]);
            e.done = (m_row == H-1) && (m_col == W-1);
            sb_q.push_back(e);
        end
        if (m_col == W-1) begin
            m_col = 0;
            m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic send(input logic [P-1:0] v, input logic sof);
        push_model(v, sof);
        px_valid_i = 1'b1;
        px_gray_i  = v;
        sof_i      = sof;
        @(posedge clk);
        #1;
        px_valid_i = 1'b0;
        sof_i      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame of pixel value 4*row+col; the first pixel may carry sof_i.
    task automatic send_frame(input int gap, input logic sof_first);
        logic [9*P-1:0] held;
        for (int k = 0; k < W*H; k++) begin
            send(P'(k), sof_first && (k == 0));
            if (k == 0)  check_bit("busy_after_first_px", busy_o, 1'b1);
            if (k == 9)  check_bit("no_valid_after_px9", window_valid_o, 1'b0);
            if (k == 10) begin
                check_bit("valid_after_px10", window_valid_o, 1'b1);
                check("first_window_timing", window_o, win_at(0));
            end
            if (k == 15) begin
                check_bit("valid_after_last_px", window_valid_o, 1'b1);
                check_bit("frame_done_with_last", frame_done_o, 1'b1);
            end
            held = window_o;
            for (int g = 0; g < gap; g++) begin
                idle(1);
                check("gap_hold_window", window_o, held);
                check_bit("gap_no_valid", window_valid_o, 1'b0);
            end
        end
    endtask

    task automatic start_phase();
        got_q.delete();
        win_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic end_frame_checks(input string tag, input int frames);
        idle(2);
        check_int({tag, "_window_count"}, win_cnt, 4*frames);
        check_int({tag, "_done_count"}, done_cnt, frames);
        check_int({tag, "_scoreboard_empty"}, sb_q.size(), 0);
        check({tag, "_first_window"}, got_q[0], win_at(0));
        check({tag, "_last_window"}, got_q[4*frames-1], win_at(5));
        check_bit({tag, "_busy_idle"}, busy_o, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset_i) begin
            if (window_valid_o) begin
                win_cnt++;
                got_q.push_back(window_o);
                n_assert++;
                assert (sb_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_window: observed %0h expected none", window_o);
                end
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("window", window_o, mon_e.win);
                    check_bit("frame_done", frame_done_o, mon_e.done);
                end
            end else if (frame_done_o) begin
                check_bit("done_without_valid", frame_done_o, 1'b0);
            end
            if (frame_done_o) done_cnt++;
        end
    end

    initial begin
        reset_i    = 1'b1;
        px_valid_i = 1'b0;
        px_gray_i  = '0;
        sof_i      = 1'b0;
        #2;
        check("reset_window", window_o, '0);
        check_bit("reset_valid", window_valid_o, 1'b0);
        check_bit("reset_done", frame_done_o, 1'b0);
        check_bit("reset_busy", busy_o, 1'b0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Back-to-back single frame
        start_phase();
        send_frame(0, 1'b0);
        end_frame_checks("b2b", 1);

        // Same frame with idle gaps between pixels
        start_phase();
        send_frame(3, 1'b0);
        end_frame_checks("gap", 1);

        // Two frames without a gap
        start_phase();
        send_frame(0, 1'b0);
        send_frame(0, 1'b0);
        end_frame_checks("two_frames", 2);
        check("second_frame_first_window", got_q[4], win_at(0));
        check("first_frame_last_window", got_q[3], win_at(5));

        // Restart by sof_i after pixel 7
        start_phase();
        for (int k = 0; k < 8; k++) send(P'(k), 1'b0);
        send_frame(0, 1'b1);
        end_frame_checks("sof_restart", 1);

        // Asynchronous reset mid-frame after pixel 11
        for (int k = 0; k < 12; k++) send(P'(k), 1'b0);
        #1;
        reset_i = 1'b1;
        sb_q.delete();
        m_row = 0;
        m_col = 0;
        #1;
        check("midreset_window", window_o, '0);
        check_bit("midreset_valid", window_valid_o, 1'b0);
        check_bit("midreset_done", frame_done_o, 1'b0);
        check_bit("midreset_busy", busy_o, 1'b0);
        #1;
        reset_i = 1'b0;
        start_phase();
        send_frame(0, 1'b0);
        end_frame_checks("after_reset", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
